hv_efuse_load_ctrl: RTL and testbench

- eFuse load sequencer that services the load request issued by the HV control FSM (WAIT_ST, no valid eFuse data).
- Reads EFUSE_WORD_NUM words from the eFuse macro with programmable setup/strobe timing and writes each word into the register bank.
- Verifies an XOR checksum word, then returns a one-cycle load-done pulse and the eFuse-valid flag to the control FSM and register bank.

---
 rtl/hv_efuse_load_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_hv_efuse_load_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hv_efuse_load_ctrl.sv
// eFuse load sequencer: reads the fuse words into the register bank, checks the
// keyed XOR checksum and reports done/valid back to the HV control FSM.
module hv_efuse_load_ctrl #(
  parameter int                      EFUSE_WORD_NUM = 8,
  parameter int                      EFUSE_ADDR_W   = 3,
  parameter int                      EFUSE_DATA_W   = 8,
  parameter int                      SETUP_CYC      = 2,
  parameter int                      STRB_CYC       = 4,
  parameter logic [EFUSE_DATA_W-1:0] CHK_KEY        = 8'hA5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_efuse_load_req,
  input  logic                    i_efuse_ctrl_reg_en,
  output logic                    o_efuse_load_done,
  output logic                    o_efuse_vld,
  output logic                    o_efuse_chk_err,
  output logic                    o_efuse_busy,
  output logic                    o_efuse_csb,
  output logic                    o_efuse_strobe,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
  input  logic [EFUSE_DATA_W-1:0] i_efuse_dout,
  output logic                    o_reg_wr_en,
  output logic [EFUSE_ADDR_W-1:0] o_reg_wr_addr,
  output logic [EFUSE_DATA_W-1:0] o_reg_wr_data
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_STRB  = 3'd2;
  localparam logic [2:0] ST_CAPT  = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int CNT_MAX = (SETUP_CYC > STRB_CYC) ? SETUP_CYC : STRB_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]        SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]        STRB_LAST  = CNT_W'(STRB_CYC - 1);
  localparam logic [EFUSE_ADDR_W-1:0] LAST_IDX   = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

  logic [2:0]              state_r, nxt_state_s;
  logic [CNT_W-1:0]        cnt_r, nxt_cnt_s;
  logic [EFUSE_ADDR_W-1:0] idx_r, nxt_idx_s;
  logic [EFUSE_DATA_W-1:0] acc_r, chk_word_r;
  logic                    req_ff_r;
  logic                    start_s, abort_s, macro_act_s;

  assign start_s     = i_efuse_load_req & ~req_ff_r & i_efuse_ctrl_reg_en & (state_r == ST_IDLE);
  assign abort_s     = ~i_efuse_ctrl_reg_en;
  assign macro_act_s = (nxt_state_s == ST_SETUP) | (nxt_state_s == ST_STRB) | (nxt_state_s == ST_CAPT);

  // Next-state, phase counter and word index
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_idx_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          nxt_state_s = ST_SETUP;
          nxt_cnt_s   = {CNT_W{1'b0}};
          nxt_idx_s   = {EFUSE_ADDR_W{1'b0}};
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (abort_s) begin
          nxt_state_s = ST_IDLE;
          nxt_cnt_s   = {CNT_W{1'b0}};
          nxt_idx_s   = {EFUSE_ADDR_W{1'b0}};
        end else if (cnt_r == SETUP_LAST) begin
          nxt_state_s = ST_STRB;
          nxt_cnt_s   = {CNT_W{1'b0}};
        end else begin
          nxt_cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_STRB: begin
        if (abort_s) begin
          nxt_state_s = ST_IDLE;
          nxt_cnt_s   = {CNT_W{1'b0}};
          nxt_idx_s   = {EFUSE_ADDR_W{1'b0}};
        end else if (cnt_r == STRB_LAST) begin
          nxt_state_s = ST_CAPT;
          nxt_cnt_s   = {CNT_W{1'b0}};
        end else begin
          nxt_cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_CAPT: begin
        if (abort_s) begin
          nxt_state_s = ST_IDLE;
          nxt_idx_s   = {EFUSE_ADDR_W{1'b0}};
        end else if (idx_r == LAST_IDX) begin
          nxt_state_s = ST_CHK;
        end else begin
          nxt_state_s = ST_SETUP;
          nxt_idx_s   = idx_r + EFUSE_ADDR_W'(1);
        end
      end
      ST_CHK: begin
        if (abort_s) begin
          nxt_state_s = ST_IDLE;
          nxt_idx_s   = {EFUSE_ADDR_W{1'b0}};
        end else begin
          nxt_state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        nxt_state_s = ST_IDLE;
        nxt_idx_s   = {EFUSE_ADDR_W{1'b0}};
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_cnt_s   = {CNT_W{1'b0}};
        nxt_idx_s   = {EFUSE_ADDR_W{1'b0}};
      end
    endcase
  end

  // Sequencer state; req_ff resets high so a request already held at reset release is not an edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      idx_r    <= {EFUSE_ADDR_W{1'b0}};
      req_ff_r <= 1'b1;
    end else begin
      state_r  <= nxt_state_s;
      cnt_r    <= nxt_cnt_s;
      idx_r    <= nxt_idx_s;
      req_ff_r <= i_efuse_load_req;
    end
  end

  // Macro and register-bank outputs, registered from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_efuse_busy      <= 1'b0;
      o_efuse_csb       <= 1'b1;
      o_efuse_strobe    <= 1'b0;
      o_efuse_addr      <= {EFUSE_ADDR_W{1'b0}};
      o_efuse_load_done <= 1'b0;
      o_reg_wr_en       <= 1'b0;
      o_reg_wr_addr     <= {EFUSE_ADDR_W{1'b0}};
      o_reg_wr_data     <= {EFUSE_DATA_W{1'b0}};
    end else begin
      o_efuse_busy      <= (nxt_state_s != ST_IDLE);
      o_efuse_csb       <= ~macro_act_s;
      o_efuse_strobe    <= (nxt_state_s == ST_STRB);
      o_efuse_addr      <= macro_act_s ? nxt_idx_s : {EFUSE_ADDR_W{1'b0}};
      o_efuse_load_done <= (nxt_state_s == ST_DONE);
      o_reg_wr_en       <= (nxt_state_s == ST_CAPT);
      o_reg_wr_addr     <= (nxt_state_s == ST_CAPT) ? nxt_idx_s : {EFUSE_ADDR_W{1'b0}};
      if ((state_r == ST_STRB) && (nxt_state_s == ST_CAPT)) begin
        o_reg_wr_data <= i_efuse_dout;
      end else begin
        o_reg_wr_data <= o_reg_wr_data;
      end
    end
  end

  // Keyed XOR accumulation over data words and checksum verdict
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_r           <= CHK_KEY;
      chk_word_r      <= {EFUSE_DATA_W{1'b0}};
      o_efuse_vld     <= 1'b0;
      o_efuse_chk_err <= 1'b0;
    end else if (start_s) begin
      acc_r           <= CHK_KEY;
      o_efuse_vld     <= 1'b0;
      o_efuse_chk_err <= 1'b0;
    end else if ((state_r == ST_CAPT) && (nxt_state_s == ST_SETUP)) begin
      acc_r <= acc_r ^ o_reg_wr_data;
    end else if ((state_r == ST_CAPT) && (nxt_state_s == ST_CHK)) begin
      chk_word_r <= o_reg_wr_data;
    end else if ((state_r == ST_CHK) && (nxt_state_s == ST_DONE)) begin
      o_efuse_vld     <= (chk_word_r == acc_r);
      o_efuse_chk_err <= (chk_word_r != acc_r);
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: tb/tb_hv_efuse_load_ctrl.sv
// Self-checking bench for hv_efuse_load_ctrl: a cycle timeline model derived from
// the load latency rules, checked every cycle with immediate assertions.
module tb_hv_efuse_load_ctrl;

  localparam int SETUP = 2;
  localparam int STRB  = 4;
  localparam int N     = 8;
  localparam int P     = SETUP + STRB + 1;

  logic       clk, rst_n, req, en;
  logic       done, vld, chk_err, busy, csb, strobe, wr_en;
  logic [2:0] addr, wr_addr;
  logic [7:0] dout, wr_data;
  logic [7:0] fuse [N];

  int errors = 0;
  int checks = 0;

  hv_efuse_load_ctrl dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_efuse_load_req    (req),
    .i_efuse_ctrl_reg_en (en),
    .o_efuse_load_done   (done),
    .o_efuse_vld         (vld),
    .o_efuse_chk_err     (chk_err),
    .o_efuse_busy        (busy),
    .o_efuse_csb         (csb),
    .o_efuse_strobe      (strobe),
    .o_efuse_addr        (addr),
    .i_efuse_dout        (dout),
    .o_reg_wr_en         (wr_en),
    .o_reg_wr_addr       (wr_addr),
    .o_reg_wr_data       (wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_csb"},    32'(csb),     32'd1);
    chk({tag, "_strobe"}, 32'(strobe),  32'd0);
    chk({tag, "_addr"},   32'(addr),    32'd0);
    chk({tag, "_busy"},   32'(busy),    32'd0);
    chk({tag, "_done"},   32'(done),    32'd0);
    chk({tag, "_vld"},    32'(vld),     32'd0);
    chk({tag, "_err"},    32'(chk_err), 32'd0);
    chk({tag, "_wr_en"},  32'(wr_en),   32'd0);
  endtask

  // kill_cyc = 0: full load; otherwise abort (en low) or async reset at that cycle
  task automatic run_load(input int kill_cyc, input bit kill_by_rst);
    logic [7:0] acc;
    logic       v;
    bit         live, act;
    int         k, ph;
    acc = 8'hA5;
    for (int i = 0; i < N - 1; i++) acc ^= fuse[i];
    v = (acc == fuse[N-1]);
    req = 1'b0;
    step();
    req = 1'b1;
    for (int c = 1; c <= N * P + 10; c++) begin
      step();
      live = (kill_cyc == 0) || (c <= kill_cyc);
      act  = live && (c <= N * P);
      k    = (c - 1) / P;
      ph   = (c - 1) % P;
      chk("csb",    32'(csb),    32'(!act));
      chk("strobe", 32'(strobe), 32'(act && ph >= SETUP && ph < SETUP + STRB));
      chk("wr_en",  32'(wr_en),  32'(act && ph == P - 1));
      chk("done",   32'(done),   32'(live && c == N * P + 2));
      chk("busy",   32'(busy),   32'(live && c <= N * P + 2));
      chk("vld",    32'(vld),    32'(live && c >= N * P + 2 && v));
      chk("chk_err",32'(chk_err),32'(live && c >= N * P + 2 && !v));
      if (act) chk("addr", 32'(addr), 32'(k));
      if (act && ph == P - 1) begin
        chk("wr_addr", 32'(wr_addr), 32'(k));
        chk("wr_data", 32'(wr_data), 32'(fuse[k]));
      end
      if (act && ph == SETUP + STRB - 1) dout = fuse[k];
      else dout = 8'($urandom);
      if (c == kill_cyc && !kill_by_rst) en = 1'b0;
      if (c == kill_cyc && kill_by_rst) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
      end
      if (kill_by_rst && c == kill_cyc + 2) rst_n = 1'b1;
    end
    req = 1'b0;
    en  = 1'b1;
  endtask

  task automatic set_nominal(input logic [7:0] chk_word);
    fuse = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h00};
    fuse[N-1] = chk_word;
  endtask

  initial begin
    logic [7:0] acc;
    rst_n = 1'b0;
    req   = 1'b0;
    en    = 1'b1;
    dout  = 8'h00;
    step();
    step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();
    step();

    set_nominal(8'hDA);
    run_load(0, 1'b0);
    set_nominal(8'hDB);
    run_load(0, 1'b0);
    for (int i = 0; i < N; i++) fuse[i] = 8'h00;
    run_load(0, 1'b0);

    // abort during word 3 strobe, then a fresh request restarts at address 0
    set_nominal(8'hDA);
    run_load(3 * P + SETUP + 2, 1'b0);
    run_load(0, 1'b0);

    for (int r = 0; r < 2; r++) begin
      acc = 8'hA5;
      for (int i = 0; i < N - 1; i++) begin
        fuse[i] = 8'($urandom);
        acc ^= fuse[i];
      end
      fuse[N-1] = (r == 0) ? acc : (acc ^ 8'($urandom_range(1, 255)));
      run_load(0, 1'b0);
    end

    // async reset during word 5; request stays high across release without restarting
    set_nominal(8'hDA);
    run_load(5 * P + SETUP + 2, 1'b1);
    run_load(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
